// File: rtl/spi_shift_pkg.sv
// Shared types and helpers for the SPI shift engine and its bit counter.
// Optional variable-length transfers are enabled with SPI_SHIFT_VARLEN_EN.
package spi_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

    // Plain-vector encodings so state registers stay ordinary logic.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    // Width needed to hold a count of 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Up-counter with synchronous clear, enable and terminal-count compare.
// Also used by the SCLK divider, so it carries no SPI-specific knowledge.
module spi_bit_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_at_term
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI data-path shift engine: load handshake, MSB/LSB order, split sample/shift
// strobes and a done handshake. Define SPI_SHIFT_VARLEN_EN for i_xfer_len.
module spi_shift_engine
    import spi_shift_pkg::*;
#(
    parameter int               nbits       = 8,
    parameter logic [nbits-1:0] reset_value = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load_val,
    output logic                      o_load_rdy,
    input  logic [nbits-1:0]          i_load_data,
    input  logic                      i_lsb_first,
`ifdef SPI_SHIFT_VARLEN_EN
    input  logic [cnt_w(nbits)-1:0]   i_xfer_len,
`endif
    input  logic                      i_sample_en,
    input  logic                      i_shift_en,
    input  logic                      i_in,
    output logic                      o_out,
    output logic                      o_busy,
    output logic                      o_done_val,
    input  logic                      i_done_rdy,
    output logic [nbits-1:0]          o_done_data
);

    localparam int CW = cnt_w(nbits);

    logic [1:0]       r_state;
    logic [nbits-1:0] r_shreg;
    logic             r_lsb;
    logic             r_sampled;
    logic             r_done_val;

    logic             w_load_fire;
    logic             w_shift_fire;
    logic             w_done_fire;
    logic             w_bit;
    logic             w_last;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_term;
    logic             w_at_term;
    logic             w_cnt_en;

    assign w_load_fire  = (r_state == ST_IDLE)  && i_load_val;
    assign w_shift_fire = (r_state == ST_SHIFT) && i_shift_en;
    assign w_done_fire  = (r_state == ST_DONE)  && r_done_val && i_done_rdy;

    // Same-cycle sample bypasses the stored bit so CPHA-style edges coincide.
    assign w_bit  = i_sample_en ? i_in : r_sampled;
    assign w_last = w_shift_fire && w_at_term;

`ifdef SPI_SHIFT_VARLEN_EN
    logic [CW-1:0] r_len;
    logic [CW-1:0] w_len_req;

    assign w_len_req = ((i_xfer_len == '0) || (i_xfer_len > CW'(nbits)))
                     ? CW'(nbits) : i_xfer_len;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len <= CW'(nbits);
        end else if (w_load_fire) begin
            r_len <= w_len_req;
        end
    end

    assign w_term = r_len - CW'(1);
`else
    assign w_term = CW'(nbits - 1);
`endif

    // Saturate at nbits so the count can never wrap.
    assign w_cnt_en = w_shift_fire && (w_count != CW'(nbits));

    spi_bit_counter #(
        .W (CW)
    ) u_bit_counter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_load_fire),
        .i_en      (w_cnt_en),
        .i_term    (w_term),
        .o_count   (w_count),
        .o_at_term (w_at_term)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_load_fire) r_state <= ST_SHIFT;
                ST_SHIFT: if (w_last)      r_state <= ST_DONE;
                ST_DONE:  if (w_done_fire) r_state <= ST_IDLE;
                default:                   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg <= reset_value;
            r_lsb   <= 1'b0;
        end else if (w_load_fire) begin
            r_shreg <= i_load_data;
            r_lsb   <= i_lsb_first;
        end else if (w_shift_fire) begin
            if (r_lsb) begin
                r_shreg <= {w_bit, r_shreg[nbits-1:1]};
            end else begin
                r_shreg <= {r_shreg[nbits-2:0], w_bit};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sampled <= 1'b0;
        end else if ((r_state == ST_SHIFT) && i_sample_en) begin
            r_sampled <= i_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done_val <= 1'b0;
        end else if (w_last) begin
            r_done_val <= 1'b1;
        end else if (w_done_fire) begin
            r_done_val <= 1'b0;
        end
    end

    assign o_load_rdy  = (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_SHIFT);
    assign o_done_val  = r_done_val;
    assign o_done_data = r_shreg;
    assign o_out       = r_lsb ? r_shreg[0] : r_shreg[nbits-1];

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine (nbits=8, reset_value=8'hA5).
module tb_spi_shift_engine;

    localparam int         NB = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_val, load_rdy, lsb_first;
    logic [7:0] load_data;
    logic       sample_en, shift_en;
    logic       in_drv, loopback, dut_in;
    logic       out_bit, busy, done_val, done_rdy;
    logic [7:0] done_data;
`ifdef SPI_SHIFT_VARLEN_EN
    logic [3:0] xfer_len = 4'd0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign dut_in = loopback ? out_bit : in_drv;

    spi_shift_engine #(
        .nbits       (NB),
        .reset_value (RV)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_load_val  (load_val),
        .o_load_rdy  (load_rdy),
        .i_load_data (load_data),
        .i_lsb_first (lsb_first),
`ifdef SPI_SHIFT_VARLEN_EN
        .i_xfer_len  (xfer_len),
`endif
        .i_sample_en (sample_en),
        .i_shift_en  (shift_en),
        .i_in        (dut_in),
        .o_out       (out_bit),
        .o_busy      (busy),
        .o_done_val  (done_val),
        .i_done_rdy  (done_rdy),
        .o_done_data (done_data)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] d, input logic lsb);
        load_data = d;
        lsb_first = lsb;
        load_val  = 1'b1;
        tick();
        load_val  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++; if (load_rdy !== 1'b1) begin n_err++; $display("FAIL reset_load_rdy: got %b want 1", load_rdy); end
        n_vec++; if (done_val !== 1'b0) begin n_err++; $display("FAIL reset_done_val: got %b want 0", done_val); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (out_bit !== 1'b1) begin n_err++; $display("FAIL reset_out: got %b want 1", out_bit); end
        n_vec++; if (done_data !== RV) begin n_err++; $display("FAIL reset_done_data: got %h want %h", done_data, RV); end
        $display("reset: done_data=%h load_rdy=%b", done_data, load_rdy);
    endtask

    task automatic test_msb_loopback;
        logic [7:0] exp_word;
        exp_word = 8'hC3;
        loopback = 1'b1;
        do_load(exp_word, 1'b0);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL msb_busy: got %b want 1", busy); end
        n_vec++; if (load_rdy !== 1'b0) begin n_err++; $display("FAIL msb_load_rdy: got %b want 0", load_rdy); end
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (out_bit !== exp_word[7-i]) begin n_err++; $display("FAIL msb_out_bit%0d: got %b want %b", i, out_bit, exp_word[7-i]); end
            n_vec++; if (done_val !== 1'b0) begin n_err++; $display("FAIL msb_early_done%0d: got %b want 0", i, done_val); end
            sample_en = 1'b1; tick(); sample_en = 1'b0;
            shift_en  = 1'b1; tick(); shift_en  = 1'b0;
        end
        n_vec++; if (done_val !== 1'b1) begin n_err++; $display("FAIL msb_done_val: got %b want 1", done_val); end
        n_vec++; if (done_data !== 8'hC3) begin n_err++; $display("FAIL msb_done_data: got %h want c3", done_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL msb_done_busy: got %b want 0", busy); end
        done_rdy = 1'b1; tick(); done_rdy = 1'b0;
        n_vec++; if (load_rdy !== 1'b1) begin n_err++; $display("FAIL msb_back_idle: got %b want 1", load_rdy); end
        n_vec++; if (done_val !== 1'b0) begin n_err++; $display("FAIL msb_done_clear: got %b want 0", done_val); end
        loopback = 1'b0;
        $display("msb loopback: done_data=%h", done_data);
    endtask

    task automatic test_lsb_first;
        logic [7:0] seq;
        seq = 8'b0000_0001;
        do_load(8'h01, 1'b1);
        lsb_first = 1'b0;
        n_vec++; if (out_bit !== 1'b1) begin n_err++; $display("FAIL lsb_first_out: got %b want 1", out_bit); end
        for (int i = 0; i < 8; i++) begin
            in_drv = seq[i];
            sample_en = 1'b1; tick(); sample_en = 1'b0;
            shift_en  = 1'b1; tick(); shift_en  = 1'b0;
            if (i == 0) begin
                n_vec++; if (out_bit !== 1'b0) begin n_err++; $display("FAIL lsb_second_out: got %b want 0", out_bit); end
            end
        end
        n_vec++; if (done_val !== 1'b1) begin n_err++; $display("FAIL lsb_done_val: got %b want 1", done_val); end
        n_vec++; if (done_data !== 8'h01) begin n_err++; $display("FAIL lsb_done_data: got %h want 01", done_data); end
        done_rdy = 1'b1; tick(); done_rdy = 1'b0;
        $display("lsb first: done_data=%h", done_data);
    endtask

    task automatic test_bypass;
        do_load(8'h00, 1'b0);
        in_drv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample_en = 1'b1; shift_en = 1'b1; tick();
        end
        sample_en = 1'b0; shift_en = 1'b0;
        n_vec++; if (done_val !== 1'b1) begin n_err++; $display("FAIL bypass_done_val: got %b want 1", done_val); end
        n_vec++; if (done_data !== 8'hFF) begin n_err++; $display("FAIL bypass_done_data: got %h want ff", done_data); end
        $display("bypass: done_data=%h", done_data);
    endtask

    task automatic test_backpressure;
        in_drv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_val = 1'b1; load_data = 8'h3C; shift_en = 1'b1; sample_en = 1'b1;
            tick();
            n_vec++; if (done_val !== 1'b1) begin n_err++; $display("FAIL bp_done_val%0d: got %b want 1", i, done_val); end
            n_vec++; if (done_data !== 8'hFF) begin n_err++; $display("FAIL bp_done_data%0d: got %h want ff", i, done_data); end
            n_vec++; if (load_rdy !== 1'b0) begin n_err++; $display("FAIL bp_load_rdy%0d: got %b want 0", i, load_rdy); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy%0d: got %b want 0", i, busy); end
        end
        load_val = 1'b0; shift_en = 1'b0; sample_en = 1'b0;
        done_rdy = 1'b1; tick(); done_rdy = 1'b0;
        n_vec++; if (load_rdy !== 1'b1) begin n_err++; $display("FAIL bp_release_load_rdy: got %b want 1", load_rdy); end
        n_vec++; if (done_val !== 1'b0) begin n_err++; $display("FAIL bp_release_done_val: got %b want 0", done_val); end
        n_vec++; if (done_data !== 8'hFF) begin n_err++; $display("FAIL bp_idle_data: got %h want ff", done_data); end
        $display("backpressure: released, load_rdy=%b", load_rdy);
    endtask

    task automatic test_midreset;
        do_load(8'h5A, 1'b0);
        in_drv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'b1; shift_en = 1'b1; tick();
        end
        sample_en = 1'b0; shift_en = 1'b0;
        n_vec++; if (done_data !== 8'hD0) begin n_err++; $display("FAIL mid_partial_data: got %h want d0", done_data); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_vec++; if (load_rdy !== 1'b1) begin n_err++; $display("FAIL mid_load_rdy: got %b want 1", load_rdy); end
        n_vec++; if (done_data !== RV) begin n_err++; $display("FAIL mid_shreg: got %h want %h", done_data, RV); end
        n_vec++; if (done_val !== 1'b0) begin n_err++; $display("FAIL mid_done_val: got %b want 0", done_val); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (done_val !== 1'b0) begin n_err++; $display("FAIL mid_post_done_val: got %b want 0", done_val); end
        loopback = 1'b1;
        do_load(8'h96, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                n_vec++; if (done_val !== 1'b0) begin n_err++; $display("FAIL mid_rerun_early: got %b want 0", done_val); end
            end
            sample_en = 1'b1; shift_en = 1'b1; tick();
        end
        sample_en = 1'b0; shift_en = 1'b0; loopback = 1'b0;
        n_vec++; if (done_val !== 1'b1) begin n_err++; $display("FAIL mid_rerun_done_val: got %b want 1", done_val); end
        n_vec++; if (done_data !== 8'h96) begin n_err++; $display("FAIL mid_rerun_data: got %h want 96", done_data); end
        done_rdy = 1'b1; tick(); done_rdy = 1'b0;
        $display("mid-transfer reset: rerun done_data=%h", done_data);
    endtask

    initial begin
        rst_n = 1'b0; load_val = 1'b0; load_data = 8'h00; lsb_first = 1'b0;
        sample_en = 1'b0; shift_en = 1'b0; in_drv = 1'b0; loopback = 1'b0;
        done_rdy = 1'b0;
        test_reset();
        test_msb_loopback();
        test_lsb_first();
        test_bypass();
        test_backpressure();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Parametrised SPI data-path shift engine, successor to the plain N-bit shift register. Adds a load handshake, MSB/LSB-first selection, split sample/shift strobes (for CPHA timing), an internal bit counter, and a completion handshake that presents the received word. It sits between the SPI master/minion control FSM (which supplies strobes from the SCLK generator) and the message-level val/rdy interfaces.

Parameters:
nbits, 8, transfer word width; legal range 2..64
reset_value, 0, value loaded into the shift register on reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
load_val  in  1  parallel-load request
load_rdy  out  1  engine can accept a load
load_data  in  nbits  word to transmit
lsb_first  in  1  bit order, sampled at load handshake
sample_en  in  1  capture in_ this cycle (sampling SCLK edge)
shift_en  in  1  shift one bit this cycle (launch SCLK edge)
in_  in  1  serial data in (MISO/MOSI depending on role)
out_  out  1  serial data out, current bit being driven
busy  out  1  high in SHIFT state
done_val  out  1  received word available
done_rdy  in  1  consumer accepts received word
done_data  out  nbits  received word, always in load_data bit order

Behaviour:
- State machine: IDLE -> SHIFT on load_val&&load_rdy; SHIFT -> DONE on the nbits-th accepted shift_en; DONE -> IDLE on done_val&&done_rdy.
- Reset (reset==0, async): state=IDLE, shreg=reset_value, bit count=0, sampled bit=0, order flag=0 (MSB first), done_val=0, busy=0, load_rdy=1 after release.
- load_rdy=1 only in IDLE. Load accepted: shreg<=load_data, order flag<=lsb_first, count<=0; load_val outside IDLE is ignored.
- out_ = shreg[nbits-1] if MSB-first else shreg[0]; combinational from the flops; valid in the cycle after load.
- sample_en in SHIFT: sampled bit <= in_. Ignored in IDLE/DONE.
- shift_en in SHIFT: MSB-first shreg <= {shreg[nbits-2:0], b}; LSB-first shreg <= {b, shreg[nbits-1:1]}; count++.
- b = in_ if sample_en is high in the same cycle (bypass), else the stored sampled bit.
- shift_en in IDLE/DONE is ignored, and the count does not move.
- The count is $clog2(nbits+1) bits wide. When count reaches nbits-1 and shift_en fires, go to DONE; count does not wrap.
- done_data = shreg; held stable while done_val=1. done_val is registered and equals (state==DONE).
- done_val&&done_rdy returns to IDLE; load_rdy rises the next cycle. There is no same-cycle done-to-load bypass.
- Reset asserted mid-transfer aborts immediately; no done_val is produced.

Optional Feature:
Macro SPI_SHIFT_VARLEN_EN.
- Defined: adds input xfer_len [$clog2(nbits+1)-1:0], captured at load. The transfer ends after xfer_len shifts; xfer_len of 0 or greater than nbits is treated as nbits.
- Defined, short transfers: received bits are right-aligned in done_data for MSB-first and left-aligned for LSB-first. Unshifted bits keep their loaded value.
- Undefined: no port; every transfer is exactly nbits.

Decomposition:
- Package spi_shift_pkg holds the state enum typedef (IDLE, SHIFT, DONE) and a count-width localparam function cnt_w(nbits)=$clog2(nbits+1).
- One natural sub-module, spi_bit_counter: parametrised up-counter with clear, enable and terminal-count compare. It is reused by the SCLK divider.

Test Plan:
- Reset: hold reset=0 with reset_value=8'hA5, release -> load_rdy=1, done_val=0, busy=0, out_=1, done_data=8'hA5.
- MSB-first loopback (in_ tied to out_): load 8'hC3, then 8 pulses of sample_en followed by shift_en -> done_val=1 after the 8th shift, done_data=8'hC3, out_ sequence 1,1,0,0,0,0,1,1.
- LSB-first: lsb_first=1, load 8'h01, in_ driven 1,0,0,0,0,0,0,0 -> out_ first bit=1; done_data=8'h01.
- Same-cycle sample and shift: sample_en and shift_en asserted together with in_=1 every bit -> done_data=8'hFF (bypass used).
- Backpressure and ignored inputs: done_rdy=0 for 5 cycles while pulsing load_val and shift_en -> state stays DONE, done_data stable, load_rdy=0. Then done_rdy=1 -> IDLE, with load_rdy=1 the next cycle.
- Mid-transfer reset: pull reset=0 after 3 shifts -> IDLE immediately, shreg=reset_value, no done_val. A subsequent full transfer is correct.
